// File: rtl/unescaper.sv
// unescaper: strips ESCAPE_BYTE prefixes from an AXI4-Stream byte stream
// Ports:
//   aclk, aresetn             clock, asynchronous active-low reset
//   target_t{valid,ready,data,last}    escaped input stream
//   initiator_t{valid,ready,data,last} unescaped output stream (registered)
//   esc_err                   pulse: escape byte accepted with tlast (dangling escape)
//   ctrl_err                  pulse: unescaped START_BYTE/STOP_BYTE accepted
module unescaper #(
   parameter logic [7:0] START_BYTE  = 8'h7D,
   parameter logic [7:0] STOP_BYTE   = 8'h7E,
   parameter logic [7:0] ESCAPE_BYTE = 8'h7F
) (
   input  logic       aclk,
   input  logic       aresetn,
   input  logic       target_tvalid,
   output logic       target_tready,
   input  logic [7:0] target_tdata,
   input  logic       target_tlast,
   output logic       initiator_tvalid,
   input  logic       initiator_tready,
   output logic [7:0] initiator_tdata,
   output logic       initiator_tlast,
   output logic       esc_err,
   output logic       ctrl_err
);
   logic       esc_pending;
   logic       h_valid, h_last, o_valid, o_last;
   logic [7:0] h_data, o_data;
   logic       o_free, acc, esc_beat, data_beat, h_rel;
   assign o_free        = !o_valid || initiator_tready;
   assign target_tready = !h_valid || o_free;
   assign acc           = target_tvalid && target_tready;
   assign esc_beat      = acc && !esc_pending && target_tdata == ESCAPE_BYTE;
   assign data_beat     = acc && !esc_beat;
   // A held byte leaves only once its successor arrives or it is known to end the packet,
   // so a trailing dangling escape can still mark it as last.
   assign h_rel         = o_free && h_valid && (h_last || data_beat);
   assign initiator_tvalid = o_valid;
   assign initiator_tdata  = o_data;
   assign initiator_tlast  = o_last;
   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) begin
         esc_pending <= 1'b0;
         h_valid     <= 1'b0;
         h_data      <= 8'h00;
         h_last      <= 1'b0;
         o_valid     <= 1'b0;
         o_data      <= 8'h00;
         o_last      <= 1'b0;
         esc_err     <= 1'b0;
         ctrl_err    <= 1'b0;
      end else begin
         esc_err  <= esc_beat && target_tlast;
         ctrl_err <= data_beat && !esc_pending &&
                     (target_tdata == START_BYTE || target_tdata == STOP_BYTE);
         if (acc) esc_pending <= esc_beat && !target_tlast;
         if (data_beat) begin
            h_valid <= 1'b1;
            h_data  <= target_tdata;
            h_last  <= target_tlast;
         end else if (h_rel) h_valid <= 1'b0;
         else if (esc_beat && target_tlast && h_valid) h_last <= 1'b1;
         if (h_rel) begin
            o_valid <= 1'b1;
            o_data  <= h_data;
            o_last  <= h_last;
         end else if (initiator_tready) o_valid <= 1'b0;
      end
endmodule

// File: tb/tb_unescaper.sv
// tb_unescaper: directed and randomized checks of unescaper against a packet-level model
module tb_unescaper;
   typedef logic [8:0] beat_t;
   logic       aclk = 1'b0;
   logic       aresetn = 1'b0;
   logic       target_tvalid = 1'b0;
   logic       target_tready;
   logic [7:0] target_tdata = 8'h00;
   logic       target_tlast = 1'b0;
   logic       initiator_tvalid;
   logic       initiator_tready = 1'b1;
   logic [7:0] initiator_tdata;
   logic       initiator_tlast;
   logic       esc_err, ctrl_err;
   beat_t      in_q[$], exp_q[$], got_q[$];
   int         tests = 0, fails = 0;
   int         esc_cnt = 0, ctrl_cnt = 0, exp_esc = 0, exp_ctrl = 0;
   bit         rnd_ready = 1'b0;
   unescaper dut (
      .aclk(aclk), .aresetn(aresetn),
      .target_tvalid(target_tvalid), .target_tready(target_tready),
      .target_tdata(target_tdata), .target_tlast(target_tlast),
      .initiator_tvalid(initiator_tvalid), .initiator_tready(initiator_tready),
      .initiator_tdata(initiator_tdata), .initiator_tlast(initiator_tlast),
      .esc_err(esc_err), .ctrl_err(ctrl_err)
   );
   always #5 aclk = ~aclk;
   initial forever begin
      @(posedge aclk);
      #1;
      initiator_tready = rnd_ready ? ($urandom_range(0, 9) >= 3) : 1'b1;
   end
   // Monitor: records handshakes, counts error pulses, checks stability under stall.
   initial begin
      bit    stalled;
      beat_t held;
      stalled = 1'b0;
      held = '0;
      forever begin
         @(negedge aclk);
         if (stalled && initiator_tvalid) begin
            tests++;
            assert ({initiator_tlast, initiator_tdata} === held) else begin
               fails++;
               $error("FAIL stall_stable got=%h exp=%h", {initiator_tlast, initiator_tdata}, held);
            end
         end
         stalled = initiator_tvalid && !initiator_tready;
         held = {initiator_tlast, initiator_tdata};
         if (initiator_tvalid && initiator_tready) got_q.push_back({initiator_tlast, initiator_tdata});
         if (esc_err) esc_cnt++;
         if (ctrl_err) ctrl_cnt++;
      end
   end
   // Reference: decode the escaped beat list packet by packet.
   task automatic model();
      bit pend;
      int n;
      pend = 1'b0;
      n = 0;
      exp_q.delete();
      exp_esc = 0;
      exp_ctrl = 0;
      foreach (in_q[i]) begin
         logic [7:0] b;
         logic       l;
         b = in_q[i][7:0];
         l = in_q[i][8];
         if (!pend && b == 8'h7F) begin
            if (l) begin
               exp_esc++;
               if (n > 0) exp_q[exp_q.size()-1][8] = 1'b1;
               n = 0;
            end else pend = 1'b1;
         end else begin
            if (!pend && (b == 8'h7D || b == 8'h7E)) exp_ctrl++;
            exp_q.push_back({l, b});
            n = l ? 0 : n + 1;
            pend = 1'b0;
         end
      end
   endtask
   task automatic start();
      model();
      got_q.delete();
      esc_cnt = 0;
      ctrl_cnt = 0;
   endtask
   task automatic send(input beat_t b);
      bit ok;
      ok = 1'b0;
      target_tvalid = 1'b1;
      {target_tlast, target_tdata} = b;
      for (int k = 0; k < 1000 && !ok; k++) begin
         @(negedge aclk);
         ok = target_tready;
      end
      if (!ok) begin
         fails++;
         $display("FAIL send_timeout got=tready_low exp=accept beat=%h", b);
      end
      @(posedge aclk);
      #1;
      target_tvalid = 1'b0;
   endtask
   task automatic finish_pkt(input string tag);
      for (int k = 0; k < 1000 && got_q.size() < exp_q.size(); k++) @(negedge aclk);
      repeat (4) @(negedge aclk);
      tests++;
      assert (got_q.size() === exp_q.size()) else begin
         fails++;
         $error("FAIL %s_count got=%0d exp=%0d", tag, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         tests++;
         assert (got_q[i] === exp_q[i]) else begin
            fails++;
            $error("FAIL %s_beat%0d got=%h exp=%h", tag, i, got_q[i], exp_q[i]);
         end
      end
      tests++;
      assert (esc_cnt === exp_esc) else begin
         fails++;
         $error("FAIL %s_esc_err got=%0d exp=%0d", tag, esc_cnt, exp_esc);
      end
      tests++;
      assert (ctrl_cnt === exp_ctrl) else begin
         fails++;
         $error("FAIL %s_ctrl_err got=%0d exp=%0d", tag, ctrl_cnt, exp_ctrl);
      end
      @(posedge aclk);
      #1;
   endtask
   initial begin
      // reset state
      repeat (2) @(negedge aclk);
      tests++;
      assert ({initiator_tvalid, initiator_tdata, initiator_tlast, esc_err, ctrl_err} === 12'h000) else begin
         fails++;
         $error("FAIL reset_outputs got=%h exp=000",
                {initiator_tvalid, initiator_tdata, initiator_tlast, esc_err, ctrl_err});
      end
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      @(negedge aclk);
      tests++;
      assert (target_tready === 1'b1) else begin
         fails++;
         $error("FAIL reset_tready got=%b exp=1", target_tready);
      end
      @(posedge aclk);
      #1;
      // 41 7F 7D 42(last): latency of the last byte
      in_q = '{9'h041, 9'h07F, 9'h07D, 9'h142};
      start();
      foreach (in_q[i]) send(in_q[i]);
      tests++;
      assert ((initiator_tvalid && initiator_tlast) === 1'b0) else begin
         fails++;
         $error("FAIL lat_early got=%b exp=0", initiator_tvalid && initiator_tlast);
      end
      @(posedge aclk);
      #1;
      tests++;
      assert ({initiator_tvalid, initiator_tlast, initiator_tdata} === 10'h342) else begin
         fails++;
         $error("FAIL lat_two got=%h exp=342", {initiator_tvalid, initiator_tlast, initiator_tdata});
      end
      finish_pkt("t1");
      in_q = '{9'h07F, 9'h07F, 9'h07F, 9'h17E};
      start();
      foreach (in_q[i]) send(in_q[i]);
      finish_pkt("t2");
      in_q = '{9'h041, 9'h17F, 9'h155};
      start();
      foreach (in_q[i]) send(in_q[i]);
      finish_pkt("t3");
      in_q = '{9'h17F};
      start();
      send(in_q[0]);
      @(negedge aclk);
      tests++;
      assert (target_tready === 1'b1) else begin
         fails++;
         $error("FAIL t4_tready got=%b exp=1", target_tready);
      end
      finish_pkt("t4");
      // full byte range through an escaper, random backpressure
      in_q.delete();
      for (int b = 0; b < 256; b++) begin
         if (b >= 8'h7D && b <= 8'h7F) in_q.push_back(9'h07F);
         in_q.push_back({b == 255, 8'(b)});
      end
      rnd_ready = 1'b1;
      start();
      foreach (in_q[i]) send(in_q[i]);
      finish_pkt("t5");
      // random multi-packet traffic biased toward control bytes
      for (int p = 0; p < 4; p++) begin
         in_q.delete();
         for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            b = ($urandom_range(0, 1) == 0) ? 8'(8'h7D + $urandom_range(0, 2)) : 8'($urandom);
            in_q.push_back({(i == 39) || ($urandom_range(0, 7) == 0), b});
         end
         start();
         foreach (in_q[i]) send(in_q[i]);
         finish_pkt("rnd");
      end
      rnd_ready = 1'b0;
      // reset with a pending escape
      send(9'h07F);
      aresetn = 1'b0;
      repeat (2) begin
         @(negedge aclk);
         tests++;
         assert (initiator_tvalid === 1'b0) else begin
            fails++;
            $error("FAIL t6_rst_valid got=%b exp=0", initiator_tvalid);
         end
      end
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      in_q = '{9'h17D};
      start();
      send(in_q[0]);
      finish_pkt("t6");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
